// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// Loadable down-counting timer with one-shot / auto-reload modes and a clock
// prescaler. A load captures a start value, start begins counting and a
// one-cycle done pulse is produced when the count expires (1 -> 0 / reload).
//
// Parameters
//   WIDTH     counter and load-value width in bits
//   PRESCALE  enabled RUN clocks per decrement tick (>= 1)
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   load_i          capture load_value_i into count and reload register
//   load_value_i    value captured on load
//   start_i         begin/resume counting (IDLE -> RUN)
//   stop_i          pause counting (RUN -> IDLE), count held
//   auto_reload_i   1: reload on expiry and keep running, 0: one-shot
//   enable_i        clock qualifier for prescaler / count advance
//   count_o         current count (registered)
//   busy_o          1 while in RUN
//   done_o          one-cycle expiry pulse (registered)
//   zero_o          combinational count == 0
// -----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             auto_reload_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o
);

  // Prescaler needs at least one bit even when PRESCALE == 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0]    PRESC_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (load_i) begin
      count_d  = load_value_i;
      reload_d = load_value_i;
      presc_d  = PRESC_ZERO;
      // Loading zero while running would leave RUN with nothing to count.
      if (state_q == ST_RUN && load_value_i == CNT_ZERO) begin
        state_d = ST_IDLE;
      end
    end else if (stop_i) begin
      // stop consumes the edge; it only changes anything while running.
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
        presc_d = PRESC_ZERO;
      end
    end else if (state_q == ST_IDLE) begin
      if (start_i && count_q != CNT_ZERO) begin
        state_d = ST_RUN;
      end
    end else if (enable_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = PRESC_ZERO;
        // Tick: expiry is detected at 1 so the count never wraps.
        if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else if (count_q == CNT_ONE) begin
          done_d = 1'b1;
          if (auto_reload_i) begin
            count_d = reload_q;
          end else begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      presc_q  <= PRESC_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;
  assign zero_o  = (count_q == CNT_ZERO);

endmodule
